// File: rtl/servo_ramp_ctrl_pkg.sv
// Shared definitions for the servo ramp controller.
//   state_e      : controller state encoding
//   DEF_*        : default parameter values of servo_ramp_ctrl
//   PROF_W       : width of one profile table entry (delay in PWM periods)
//   DEF_PROFILE  : default per-step delay table, entry 0 in the low byte
package servo_ramp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PLAN   = 3'd2,
        ST_ACCEL  = 3'd3,
        ST_CRUISE = 3'd4,
        ST_DECEL  = 3'd5,
        ST_HOLD   = 3'd6
    } state_e;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_STEPS          = 8;
    localparam int DEF_SETTLE_PERIODS = 32;
    localparam int DEF_ACCEL_THRESH   = 16;
    localparam int PROF_W             = 8;

    // PROFILE[0] = 0x70 (slowest) ... PROFILE[7] = 0x18 (cruise delay)
    localparam logic [DEF_STEPS*PROF_W-1:0] DEF_PROFILE =
        {8'h18, 8'h20, 8'h28, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};

endpackage

// File: rtl/servo_ramp_ctrl_pwm.sv
// servo_pwm_core: free-running PWM generator.
//   clock_i/reset_i : clock, asynchronous active-high reset
//   run_i           : output enable (pwm_o forced low when 0)
//   ratio_i         : requested duty; sampled at counter wrap
//   pwm_o           : high while counter < latched ratio
//   period_tick_o   : one-cycle pulse when the counter is all-ones
module servo_pwm_core
    import servo_ramp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] ratio_i,
    output logic             pwm_o,
    output logic             period_tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] ratio_q;

    // Period counter and ratio latch; the ratio only changes at a period
    // boundary so a pulse is never cut short or stretched mid-period.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            ratio_q <= '0;
        end else begin
            cnt_q <= cnt_q + WIDTH'(1);
            if (cnt_q == '1) begin
                ratio_q <= ratio_i;
            end else begin
                ratio_q <= ratio_q;
            end
        end
    end

    assign period_tick_o = (cnt_q == '1);
    assign pwm_o         = run_i & (cnt_q < ratio_q);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: moves a PWM ratio toward a requested target one LSB at a
// time, with a trapezoidal (accelerate / cruise / decelerate) delay profile
// for long moves and constant cruise pacing for short ones.
//   clock_i, reset_i        : clock, asynchronous active-high reset
//   enable_i                : run level; low returns to IDLE
//   start_ratio_i           : ratio loaded on leaving IDLE
//   target_ratio_i/valid_i  : new target offer (0 = back to start ratio)
//   target_ready_o          : offer accepted when valid & ready
//   pwm_signal_o            : PWM output
//   curr_ratio_o            : ratio currently driving the PWM
//   busy_o                  : SETTLE / PLAN / ACCEL / CRUISE / DECEL
//   at_target_o             : HOLD with no pending target
module servo_ramp_ctrl
    import servo_ramp_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int STEPS          = DEF_STEPS,
    parameter int SETTLE_PERIODS = DEF_SETTLE_PERIODS,
    parameter int ACCEL_THRESH   = DEF_ACCEL_THRESH,
    parameter logic [STEPS*PROF_W-1:0] PROFILE = DEF_PROFILE
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] start_ratio_i,
    input  logic [WIDTH-1:0] target_ratio_i,
    input  logic             target_valid_i,
    output logic             target_ready_o,
    output logic             pwm_signal_o,
    output logic [WIDTH-1:0] curr_ratio_o,
    output logic             busy_o,
    output logic             at_target_o
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CW = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam logic [WIDTH:0]  THRESH_D    = (WIDTH+1)'(ACCEL_THRESH);
    localparam logic [WIDTH:0]  DECEL_D     = (WIDTH+1)'(STEPS-1);
    localparam logic [SW-1:0]   LAST_ACCEL  = SW'(STEPS-2);
    localparam logic [CW-1:0]   LAST_SETTLE = CW'(SETTLE_PERIODS-1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    curr_q, curr_d;
    logic [WIDTH-1:0]    goal_q, goal_d;
    logic [WIDTH-1:0]    pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [CW-1:0]       settle_q, settle_d;
    logic [PROF_W-1:0]   delay_q, delay_d;
    logic [SW-1:0]       step_q, step_d;
    logic                accel_q, accel_d;

    logic                period_tick_s;
    logic [WIDTH:0]      dist_s;
    logic [WIDTH-1:0]    toward_s;
    logic [PROF_W-1:0]   limit_s;
    logic                tick_hit_s;
    logic [PROF_W-1:0]   delay_next_s;
    logic [WIDTH-1:0]    curr_next_s;

    function automatic logic [PROF_W-1:0] prof_at(input int idx);
        return PROFILE[idx*PROF_W +: PROF_W];
    endfunction

    servo_pwm_core #(.WIDTH(WIDTH)) u_pwm (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .run_i         (state_q != ST_IDLE),
        .ratio_i       (curr_q),
        .pwm_o         (pwm_signal_o),
        .period_tick_o (period_tick_s)
    );

    // Distance to goal (one extra bit so it never wraps) and the next ratio
    // one LSB toward the goal; toward_s equals curr_q once the goal is reached.
    always_comb begin
        if (goal_q > curr_q) begin
            dist_s   = {1'b0, goal_q} - {1'b0, curr_q};
            toward_s = curr_q + WIDTH'(1);
        end else begin
            dist_s   = {1'b0, curr_q} - {1'b0, goal_q};
            toward_s = (curr_q == goal_q) ? curr_q : (curr_q - WIDTH'(1));
        end
    end

    // Per-move delay: accel walks the table up, decel walks it back down
    // indexed by the distance still to go, cruise uses the last entry.
    always_comb begin
        limit_s = prof_at(STEPS-1);
        case (state_q)
            ST_ACCEL: limit_s = prof_at(int'(step_q));
            ST_DECEL: begin
                if (dist_s == '0) begin
                    limit_s = prof_at(0);
                end else if (dist_s > DECEL_D) begin
                    limit_s = prof_at(STEPS-1);
                end else begin
                    limit_s = prof_at(int'(dist_s) - 1);
                end
            end
            default:  limit_s = prof_at(STEPS-1);
        endcase
    end

    // Move rule shared by the moving states: one step per limit+1 periods.
    always_comb begin
        tick_hit_s = period_tick_s & (delay_q == limit_s);
        if (tick_hit_s) begin
            delay_next_s = '0;
            curr_next_s  = toward_s;
        end else if (period_tick_s) begin
            delay_next_s = delay_q + PROF_W'(1);
            curr_next_s  = curr_q;
        end else begin
            delay_next_s = delay_q;
            curr_next_s  = curr_q;
        end
    end

    assign target_ready_o = enable_i & ~pend_valid_q & (state_q != ST_IDLE);
    assign busy_o         = (state_q == ST_SETTLE) | (state_q == ST_PLAN) |
                            (state_q == ST_ACCEL)  | (state_q == ST_CRUISE) |
                            (state_q == ST_DECEL);
    assign at_target_o    = (state_q == ST_HOLD) & ~pend_valid_q;
    assign curr_ratio_o   = curr_q;

    // Next-state logic, target acceptance and ramp bookkeeping.
    always_comb begin
        state_d      = state_q;
        curr_d       = curr_q;
        goal_d       = goal_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        settle_d     = settle_q;
        delay_d      = delay_q;
        step_d       = step_q;
        accel_d      = accel_q;

        // ready already includes enable, so a falling enable drops the offer
        if (target_valid_i && target_ready_o) begin
            pend_valid_d = 1'b1;
            pend_d       = (target_ratio_i == '0) ? start_ratio_i : target_ratio_i;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        if (!enable_i) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    curr_d   = start_ratio_i;
                    goal_d   = (target_ratio_i == '0) ? start_ratio_i : target_ratio_i;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (period_tick_s && (settle_q == LAST_SETTLE)) begin
                        state_d = ST_PLAN;
                        delay_d = '0;
                    end else if (period_tick_s) begin
                        settle_d = settle_q + CW'(1);
                    end else begin
                        settle_d = settle_q;
                    end
                end
                ST_PLAN: begin
                    delay_d = '0;
                    step_d  = '0;
                    if (dist_s == '0) begin
                        state_d = ST_HOLD;
                        accel_d = 1'b0;
                    end else if (dist_s > THRESH_D) begin
                        state_d = ST_ACCEL;
                        accel_d = 1'b1;
                    end else begin
                        state_d = ST_CRUISE;
                        accel_d = 1'b0;
                    end
                end
                ST_ACCEL: begin
                    curr_d  = curr_next_s;
                    delay_d = delay_next_s;
                    if (tick_hit_s) begin
                        step_d = step_q + SW'(1);
                        if (step_q == LAST_ACCEL) begin
                            state_d = ST_CRUISE;
                        end else begin
                            state_d = ST_ACCEL;
                        end
                    end else begin
                        step_d = step_q;
                    end
                end
                ST_CRUISE: begin
                    if (accel_q && (dist_s <= DECEL_D)) begin
                        state_d = ST_DECEL;
                    end else if (!accel_q && (dist_s == '0)) begin
                        state_d = ST_HOLD;
                    end else begin
                        curr_d  = curr_next_s;
                        delay_d = delay_next_s;
                    end
                end
                ST_DECEL: begin
                    if (dist_s == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        curr_d  = curr_next_s;
                        delay_d = delay_next_s;
                    end
                end
                ST_HOLD: begin
                    if (pend_valid_q) begin
                        goal_d       = pend_q;
                        pend_valid_d = 1'b0;
                        state_d      = ST_PLAN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            curr_q       <= '0;
            goal_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            settle_q     <= '0;
            delay_q      <= '0;
            step_q       <= '0;
            accel_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            curr_q       <= curr_d;
            goal_q       <= goal_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            settle_q     <= settle_d;
            delay_q      <= delay_d;
            step_q       <= step_d;
            accel_q      <= accel_d;
        end
    end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Scoreboard bench for servo_ramp_ctrl with reduced timing parameters:
// WIDTH=8 (256-clock period), STEPS=4, SETTLE_PERIODS=2, ACCEL_THRESH=6,
// PROFILE = {4,3,2,1} (entry 0 first). Long move: accel intervals 5,4,3
// periods, cruise 2 periods, decel 3,4,5 periods.
module tb_servo_ramp_ctrl;

    localparam int WIDTH  = 8;
    localparam int STEPS  = 4;
    localparam int SETTLE = 2;
    localparam int THRESH = 6;
    localparam int PER    = 256;
    localparam logic [STEPS*8-1:0] PROF = {8'd1, 8'd2, 8'd3, 8'd4};

    logic             clk;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] start_ratio;
    logic [WIDTH-1:0] target_ratio;
    logic             target_valid;
    logic             target_ready;
    logic             pwm_signal;
    logic [WIDTH-1:0] curr_ratio;
    logic             busy;
    logic             at_target;

    typedef struct {
        logic [7:0] ratio;
        int         periods;   // 0: interval not checked
    } move_t;

    move_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    servo_ramp_ctrl #(
        .WIDTH(WIDTH), .STEPS(STEPS), .SETTLE_PERIODS(SETTLE),
        .ACCEL_THRESH(THRESH), .PROFILE(PROF)
    ) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .enable_i       (enable),
        .start_ratio_i  (start_ratio),
        .target_ratio_i (target_ratio),
        .target_valid_i (target_valid),
        .target_ready_o (target_ready),
        .pwm_signal_o   (pwm_signal),
        .curr_ratio_o   (curr_ratio),
        .busy_o         (busy),
        .at_target_o    (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_move(input logic [7:0] r, input int p);
        move_t m;
        m.ratio   = r;
        m.periods = p;
        exp_q.push_back(m);
    endtask

    task automatic push_run(input logic [7:0] first, input logic [7:0] last, input int p);
        logic [7:0] r;
        r = first;
        push_move(r, p);
        while (r != last) begin
            r = (last > r) ? r + 8'd1 : r - 8'd1;
            push_move(r, p);
        end
    endtask

    task automatic wait_ratio(input logic [7:0] r, input int budget, input string name);
        int n;
        n = 0;
        while (curr_ratio !== r && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, curr_ratio, r);
    endtask

    task automatic wait_hold(input int budget, input string name);
        int n;
        n = 0;
        while (at_target !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, at_target, 1);
    endtask

    task automatic duty(input logic [31:0] req, input string name);
        int hi;
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            if (pwm_signal === 1'b1) hi++;
        end
        check(name, hi, req);
    endtask

    // Monitor: every ratio change made while busy is a move; pop and compare.
    initial begin : monitor
        logic [7:0] prev_curr;
        logic       prev_busy;
        int         cyc;
        int         last_cyc;
        move_t      e;
        prev_curr = 8'd0;
        prev_busy = 1'b0;
        cyc       = 0;
        last_cyc  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1) begin
                prev_busy = 1'b0;
                prev_curr = curr_ratio;
            end else begin
                if (curr_ratio !== prev_curr && prev_busy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_move", curr_ratio, prev_curr);
                    end else begin
                        e = exp_q.pop_front();
                        check("move_ratio", curr_ratio, e.ratio);
                        if (e.periods != 0) begin
                            check("move_interval", cyc - last_cyc, e.periods * PER);
                        end
                    end
                    last_cyc = cyc;
                end
                prev_curr = curr_ratio;
                prev_busy = busy;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        start_ratio  = 8'h00;
        target_ratio = 8'h00;
        target_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_curr", curr_ratio, 0);
        check("rst_pwm", pwm_signal, 0);
        check("rst_busy", busy, 0);
        check("rst_at_target", at_target, 0);
        check("rst_ready", target_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // Long move up 0x40->0x50, then pending 0x38 taken down.
        push_move(8'h41, 0); push_move(8'h42, 4); push_move(8'h43, 3);
        push_run(8'h44, 8'h4D, 2);
        push_move(8'h4E, 3); push_move(8'h4F, 4); push_move(8'h50, 5);
        push_move(8'h4F, 0); push_move(8'h4E, 4); push_move(8'h4D, 3);
        push_run(8'h4C, 8'h3B, 2);
        push_move(8'h3A, 3); push_move(8'h39, 4); push_move(8'h38, 5);
        start_ratio  = 8'h40;
        target_ratio = 8'h50;
        enable       = 1'b1;
        @(negedge clk);
        check("load_start", curr_ratio, 8'h40);
        check("busy_settle", busy, 1);
        wait_ratio(8'h45, 30 * PER, "reach_0x45");
        target_ratio = 8'h38;
        target_valid = 1'b1;
        #1 check("ready_offer1", target_ready, 1);
        @(negedge clk);
        check("ready_after_accept", target_ready, 0);
        target_ratio = 8'h20;
        repeat (20) @(negedge clk);
        check("ready_offer2_stall", target_ready, 0);
        target_valid = 1'b0;
        wait_hold(120 * PER, "hold_0x38");
        check("final_0x38", curr_ratio, 8'h38);
        check("queue_empty_long", exp_q.size(), 0);
        repeat (3 * PER) @(negedge clk);
        check("no_second_target", curr_ratio, 8'h38);
        enable = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Target 0 means go back to start: plan straight to hold.
        start_ratio  = 8'h40;
        target_ratio = 8'h00;
        enable       = 1'b1;
        wait_hold((SETTLE + 3) * PER, "hold_zero_target");
        check("zero_target_curr", curr_ratio, 8'h40);
        duty(32'h40, "pwm_duty_0x40");
        check("queue_empty_zero", exp_q.size(), 0);
        enable = 1'b0;
        @(negedge clk);

        // Distance equal to threshold: cruise only, one move per 2 periods.
        push_move(8'h41, 0);
        push_run(8'h42, 8'h46, 2);
        start_ratio  = 8'h40;
        target_ratio = 8'h46;
        enable       = 1'b1;
        wait_hold((SETTLE + 16) * PER, "hold_cruise");
        check("cruise_curr", curr_ratio, 8'h46);
        check("queue_empty_cruise", exp_q.size(), 0);
        enable = 1'b0;
        @(negedge clk);

        // Enable drop mid-accel clears a pending target and idles the PWM.
        push_move(8'h31, 0); push_move(8'h32, 4);
        start_ratio  = 8'h30;
        target_ratio = 8'h60;
        enable       = 1'b1;
        wait_ratio(8'h32, (SETTLE + 12) * PER, "reach_0x32");
        target_ratio = 8'h10;
        target_valid = 1'b1;
        #1 check("ready_in_accel", target_ready, 1);
        @(negedge clk);
        enable       = 1'b0;
        target_ratio = 8'h70;
        #1 check("ready_enable_low", target_ready, 0);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_pwm", pwm_signal, 0);
        check("abort_curr_held", curr_ratio, 8'h32);
        repeat (4) @(negedge clk);
        target_valid = 1'b0;
        duty(0, "idle_pwm_duty");
        check("queue_empty_abort", exp_q.size(), 0);
        start_ratio  = 8'h20;
        target_ratio = 8'h20;
        enable       = 1'b1;
        @(negedge clk);
        check("reload_start", curr_ratio, 8'h20);
        check("pending_cleared", target_ready, 1);
        wait_hold((SETTLE + 3) * PER, "hold_reload");
        repeat (2 * PER) @(negedge clk);
        check("reload_still_hold", at_target, 1);
        check("reload_curr", curr_ratio, 8'h20);
        enable = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a cruise move sequence.
        push_move(8'h41, 0); push_move(8'h42, 2);
        start_ratio  = 8'h40;
        target_ratio = 8'h46;
        enable       = 1'b1;
        wait_ratio(8'h42, (SETTLE + 6) * PER, "reach_0x42");
        #3 rst = 1'b1;
        #1;
        check("arst_curr", curr_ratio, 0);
        check("arst_pwm", pwm_signal, 0);
        check("arst_busy", busy, 0);
        check("arst_at_target", at_target, 0);
        check("arst_ready", target_ready, 0);
        repeat (5) @(negedge clk);
        check("arst_curr_held", curr_ratio, 0);
        enable = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("queue_empty_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
